// File: rtl/prt_dp_pm_pkg.sv
// -----------------------------------------------------------------------------
// prt_dp_pm_pkg
// Shared definitions for the DP policy maker blocks.
//   - hpd_state_t : hot-plug-detect conditioner states
//   - default µs thresholds and clock/filter defaults for prt_dp_pm_hpd
//   - width and saturation value of the µs interval counter
// -----------------------------------------------------------------------------
package prt_dp_pm_pkg;

  typedef enum logic [1:0] {
    HPD_DISC = 2'd0,  // nothing attached
    HPD_QUAL = 2'd1,  // HPD high, waiting for it to be qualified as a plug
    HPD_CON  = 2'd2,  // sink connected, HPD high
    HPD_LOW  = 2'd3   // connected, HPD low: IRQ, glitch or unplug pending
  } hpd_state_t;

  localparam int C_CLK_FREQ_MHZ_DEF = 50;
  localparam int C_FLT_CYC_DEF      = 8;
  localparam int C_PLUG_US_DEF      = 2000;
  localparam int C_IRQ_MIN_US_DEF   = 250;
  localparam int C_UNPLUG_US_DEF    = 2000;

  // µs interval counter
  localparam int                 C_CNT_W   = 12;
  localparam logic [C_CNT_W-1:0] C_CNT_MAX = '1;

endpackage

// File: rtl/prt_dp_pm_hpd_flt.sv
// -----------------------------------------------------------------------------
// prt_dp_pm_hpd_flt
// Two-flop synchroniser followed by a run-length glitch filter.
// Q_OUT only adopts a new level after P_FLT_CYC consecutive synchronised
// samples at that level, so an edge on A_IN shows up on Q_OUT 2 + P_FLT_CYC
// cycles later; shorter excursions are discarded.
// Ports:
//   CLK_IN  in  clock
//   RST_IN  in  asynchronous reset, active high
//   A_IN    in  raw asynchronous input
//   Q_OUT   out filtered level (reset value 0)
// -----------------------------------------------------------------------------
module prt_dp_pm_hpd_flt #(
  parameter int P_FLT_CYC = 8
) (
  input  logic CLK_IN,
  input  logic RST_IN,
  input  logic A_IN,
  output logic Q_OUT
);

  localparam int                 C_RUN_W    = $clog2(P_FLT_CYC) + 1;
  localparam logic [C_RUN_W-1:0] C_RUN_LAST = C_RUN_W'(P_FLT_CYC - 1);

  logic [1:0]         sync_reg;
  logic [C_RUN_W-1:0] run_reg;
  logic [C_RUN_W-1:0] run_next;
  logic               flt_reg;
  logic               flt_next;

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      sync_reg <= 2'b00;
      run_reg  <= '0;
      flt_reg  <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], A_IN};
      run_reg  <= run_next;
      flt_reg  <= flt_next;
    end
  end

  // run_reg counts consecutive samples that disagree with the current level.
  // Since the level is binary those samples are all equal to each other; the
  // run restarts whenever a sample agrees again, and is consumed on a flip,
  // so it never exceeds P_FLT_CYC-1.
  always_comb begin
    run_next = run_reg;
    flt_next = flt_reg;
    if (sync_reg[1] == flt_reg) begin
      run_next = '0;
    end else if (run_reg >= C_RUN_LAST) begin
      flt_next = sync_reg[1];
      run_next = '0;
    end else begin
      run_next = run_reg + 1'b1;
    end
  end

  assign Q_OUT = flt_reg;

endmodule

// File: rtl/prt_dp_pm_hpd.sv
// -----------------------------------------------------------------------------
// prt_dp_pm_hpd
// Hot-plug-detect conditioner. Filters the raw HPD pin and classifies its
// pulse widths (measured in µs) as plug, unplug or IRQ_HPD.
// Ports:
//   CLK_IN     in  clock
//   RST_IN     in  asynchronous reset, active high
//   EN_IN      in  block enable; 0 holds the FSM in DISC with outputs low
//   HPD_IN     in  raw HPD pin, asynchronous
//   HPD_OUT    out qualified connected level
//   PLUG_OUT   out one-cycle pulse per plug
//   UNPLUG_OUT out one-cycle pulse per unplug
//   IRQ_OUT    out one-cycle pulse per IRQ_HPD
// -----------------------------------------------------------------------------
module prt_dp_pm_hpd
  import prt_dp_pm_pkg::*;
#(
  parameter int P_CLK_FREQ_MHZ = C_CLK_FREQ_MHZ_DEF,
  parameter int P_FLT_CYC      = C_FLT_CYC_DEF,
  parameter int P_PLUG_US      = C_PLUG_US_DEF,
  parameter int P_IRQ_MIN_US   = C_IRQ_MIN_US_DEF,
  parameter int P_UNPLUG_US    = C_UNPLUG_US_DEF
) (
  input  logic CLK_IN,
  input  logic RST_IN,
  input  logic EN_IN,
  input  logic HPD_IN,
  output logic HPD_OUT,
  output logic PLUG_OUT,
  output logic UNPLUG_OUT,
  output logic IRQ_OUT
);

  localparam int                 C_PRE_W      = (P_CLK_FREQ_MHZ > 1) ? $clog2(P_CLK_FREQ_MHZ) : 1;
  localparam logic [C_PRE_W-1:0] C_PRE_LOAD   = C_PRE_W'(P_CLK_FREQ_MHZ - 1);
  localparam logic [C_CNT_W-1:0] C_PLUG_CNT   = C_CNT_W'(P_PLUG_US);
  localparam logic [C_CNT_W-1:0] C_IRQ_CNT    = C_CNT_W'(P_IRQ_MIN_US);
  localparam logic [C_CNT_W-1:0] C_UNPLUG_CNT = C_CNT_W'(P_UNPLUG_US);

  // Elaboration-time parameter sanity checks
  if (P_CLK_FREQ_MHZ < 1) begin : g_chk_clk
    $error("prt_dp_pm_hpd: P_CLK_FREQ_MHZ must be at least 1");
  end
  if (P_FLT_CYC < 1) begin : g_chk_flt
    $error("prt_dp_pm_hpd: P_FLT_CYC must be at least 1");
  end
  if (!(P_IRQ_MIN_US < P_UNPLUG_US)) begin : g_chk_irq
    $error("prt_dp_pm_hpd: P_IRQ_MIN_US must be below P_UNPLUG_US");
  end
  if (P_UNPLUG_US > 4095) begin : g_chk_unplug
    $error("prt_dp_pm_hpd: P_UNPLUG_US must not exceed 4095");
  end
  if (P_PLUG_US > 4095) begin : g_chk_plug
    $error("prt_dp_pm_hpd: P_PLUG_US must not exceed 4095");
  end

  logic               flt;
  logic [C_PRE_W-1:0] pre_reg;
  logic [C_PRE_W-1:0] pre_next;
  logic               tick;
  logic [C_CNT_W-1:0] cnt_reg;
  logic [C_CNT_W-1:0] cnt_next;
  hpd_state_t         state_reg;
  hpd_state_t         state_next;
  logic               hpd_reg, hpd_next;
  logic               plug_reg, plug_next;
  logic               unplug_reg, unplug_next;
  logic               irq_reg, irq_next;

  prt_dp_pm_hpd_flt #(
    .P_FLT_CYC (P_FLT_CYC)
  ) u_flt (
    .CLK_IN (CLK_IN),
    .RST_IN (RST_IN),
    .A_IN   (HPD_IN),
    .Q_OUT  (flt)
  );

  // Free-running µs prescaler; never touched by EN_IN
  assign tick     = (pre_reg == '0);
  assign pre_next = tick ? C_PRE_LOAD : pre_reg - 1'b1;

  // µs interval counter: restarts on every state change (and while disabled)
  // so it always measures time spent in the current state.
  always_comb begin
    cnt_next = cnt_reg;
    if (!EN_IN || (state_next != state_reg)) begin
      cnt_next = '0;
    end else if (tick && (cnt_reg != C_CNT_MAX)) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  // State and output registers
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      pre_reg    <= C_PRE_LOAD;
      cnt_reg    <= '0;
      state_reg  <= HPD_DISC;
      hpd_reg    <= 1'b0;
      plug_reg   <= 1'b0;
      unplug_reg <= 1'b0;
      irq_reg    <= 1'b0;
    end else begin
      pre_reg    <= pre_next;
      cnt_reg    <= cnt_next;
      state_reg  <= state_next;
      hpd_reg    <= hpd_next;
      plug_reg   <= plug_next;
      unplug_reg <= unplug_next;
      irq_reg    <= irq_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (!EN_IN) begin
      state_next = HPD_DISC;
    end else begin
      case (state_reg)
        HPD_DISC: if (flt) state_next = HPD_QUAL;
        HPD_QUAL: begin
          if (!flt)                     state_next = HPD_DISC;
          else if (cnt_reg == C_PLUG_CNT) state_next = HPD_CON;
        end
        HPD_CON:  if (!flt) state_next = HPD_LOW;
        HPD_LOW: begin
          // The unplug timeout wins even if HPD has just come back
          if (cnt_reg == C_UNPLUG_CNT) state_next = HPD_DISC;
          else if (flt)                state_next = HPD_CON;
        end
        default:  state_next = HPD_DISC;
      endcase
    end
  end

  // Output decode; registered so pulses line up with the state they enter
  always_comb begin
    plug_next   = 1'b0;
    unplug_next = 1'b0;
    irq_next    = 1'b0;
    if (EN_IN) begin
      case (state_reg)
        HPD_QUAL: plug_next = flt && (cnt_reg == C_PLUG_CNT);
        HPD_LOW: begin
          unplug_next = (cnt_reg == C_UNPLUG_CNT);
          irq_next    = (cnt_reg != C_UNPLUG_CNT) && flt && (cnt_reg >= C_IRQ_CNT);
        end
        default: ;
      endcase
    end
    hpd_next = (state_next == HPD_CON) || (state_next == HPD_LOW);
  end

  assign HPD_OUT    = hpd_reg;
  assign PLUG_OUT   = plug_reg;
  assign UNPLUG_OUT = unplug_reg;
  assign IRQ_OUT    = irq_reg;

endmodule

// File: tb/tb_prt_dp_pm_hpd.sv
// -----------------------------------------------------------------------------
// tb_prt_dp_pm_hpd
// Randomised HPD waveforms built from segments whose widths sit clearly on one
// side of each threshold. Thresholds are scaled down (8 MHz clock, 30/10/30 µs)
// so the whole run stays short. Expected events with their allowed cycle
// windows are queued by the stimulus; a negedge monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_prt_dp_pm_hpd;

  localparam int C_MHZ  = 8;
  localparam int C_FLT  = 8;
  localparam int C_PLUG = 30;
  localparam int C_IRQ  = 10;
  localparam int C_UNP  = 30;

  localparam int EV_PLUG   = 1;
  localparam int EV_UNPLUG = 2;
  localparam int EV_IRQ    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic hpd = 1'b0;
  logic hpd_out, plug, unplug, irq;

  always #5 clk = ~clk;

  prt_dp_pm_hpd #(
    .P_CLK_FREQ_MHZ (C_MHZ),
    .P_FLT_CYC      (C_FLT),
    .P_PLUG_US      (C_PLUG),
    .P_IRQ_MIN_US   (C_IRQ),
    .P_UNPLUG_US    (C_UNP)
  ) dut (
    .CLK_IN     (clk),
    .RST_IN     (rst),
    .EN_IN      (en),
    .HPD_IN     (hpd),
    .HPD_OUT    (hpd_out),
    .PLUG_OUT   (plug),
    .UNPLUG_OUT (unplug),
    .IRQ_OUT    (irq)
  );

  // cyc == number of rising edges seen so far
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int lo;
    int hi;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   connected = 1'b0;

  function automatic string ev_name(int k);
    case (k)
      EV_PLUG:   return "PLUG";
      EV_UNPLUG: return "UNPLUG";
      EV_IRQ:    return "IRQ";
      default:   return "NONE";
    endcase
  endfunction

  task automatic check(string name, int act, int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Timed event: state entered (counter cleared) at edge s, threshold n_us.
  // The first tick lands 1..C_MHZ cycles after the clear and the event is
  // registered one edge after the count matches.
  task automatic push_timed(int kind, int s, int n_us);
    exp_t e;
    e.kind = kind;
    e.lo   = s + (n_us - 1) * C_MHZ + 2 - 1;
    e.hi   = s + n_us * C_MHZ + 1 + 1;
    exp_q.push_back(e);
  endtask

  task automatic push_exact(int kind, int c);
    exp_t e;
    e.kind = kind;
    e.lo   = c;
    e.hi   = c;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    int   np;
    int   kind;
    exp_t e;
    np = int'(plug) + int'(unplug) + int'(irq);
    if (np != 0) begin
      kind = plug ? EV_PLUG : (unplug ? EV_UNPLUG : EV_IRQ);
      $display("[TB] cyc=%0d event=%s hpd_out=%0b", cyc, ev_name(kind), hpd_out);
      check("pulse_exclusive", np, 1);
      if (exp_q.size() == 0) begin
        check("unexpected_event", kind, 0);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", kind, e.kind);
        n_tests++;
        if (cyc < e.lo || cyc > e.hi) begin
          n_fail++;
          $display("[TB] FAIL event_time: %s at cyc %0d, required %0d..%0d",
                   ev_name(kind), cyc, e.lo, e.hi);
        end
        check("hpd_at_event", int'(hpd_out), (kind == EV_UNPLUG) ? 0 : 1);
      end
    end
  end

  // ---------------- segments ----------------
  task automatic seg_plug();
    int k;
    hpd = 1'b1;
    k = cyc;
    push_timed(EV_PLUG, k + 3 + C_FLT, C_PLUG);
    wait_cyc(C_FLT + 4 + (C_PLUG + 2) * C_MHZ + $urandom_range(0, 40));
    connected = 1'b1;
    check("hpd_after_plug", int'(hpd_out), 1);
  endtask

  task automatic seg_short_high();
    hpd = 1'b1;
    wait_cyc($urandom_range(2 * C_FLT, (C_PLUG - 2) * C_MHZ));
    hpd = 1'b0;
    wait_cyc($urandom_range(2 * C_FLT + 4, 60));
    check("hpd_after_short_high", int'(hpd_out), 0);
  endtask

  // kind: 0 spike, 1 glitch, 2 irq, 3 chatter, 4 unplug
  task automatic seg_con(int kind);
    int k;
    int len;
    case (kind)
      0: len = $urandom_range(1, C_FLT - 2);
      1: len = $urandom_range(2 * C_FLT, (C_IRQ - 2) * C_MHZ);
      2: len = $urandom_range((C_IRQ + 2) * C_MHZ, (C_UNP - 2) * C_MHZ);
      3: len = 4 * 2 * $urandom_range(10, 25);
      default: len = C_FLT + 4 + (C_UNP + 2) * C_MHZ + $urandom_range(0, 40);
    endcase
    $display("[TB] cyc=%0d segment=%0d low_len=%0d", cyc, kind, len);
    if (kind == 3) begin
      for (int i = 0; i < len / 4; i++) begin
        hpd = ~hpd;
        wait_cyc(4);
      end
      hpd = 1'b1;
    end else begin
      hpd = 1'b0;
      k = cyc;
      if (kind == 4) push_timed(EV_UNPLUG, k + 3 + C_FLT, C_UNP);
      wait_cyc(len);
      if (kind == 4) begin
        connected = 1'b0;
        check("hpd_after_unplug", int'(hpd_out), 0);
        return;
      end
      hpd = 1'b1;
      k = cyc;
      if (kind == 2) push_exact(EV_IRQ, k + 3 + C_FLT);
    end
    wait_cyc($urandom_range(2 * C_FLT + 4, 60));
    check("hpd_stays_connected", int'(hpd_out), 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k;
    wait_cyc(4);
    check("rst_hpd", int'(hpd_out), 0);
    check("rst_plug", int'(plug), 0);
    check("rst_unplug", int'(unplug), 0);
    check("rst_irq", int'(irq), 0);
    rst = 1'b0;
    en  = 1'b1;
    wait_cyc(20);

    // Directed walk through every classification
    seg_short_high();
    seg_plug();
    seg_con(2);
    seg_con(2);
    seg_con(1);
    seg_con(0);
    seg_con(3);
    seg_con(4);
    seg_short_high();

    // Disable 15 µs into a LOW: no unplug, HPD_OUT drops next cycle
    seg_plug();
    hpd = 1'b0;
    wait_cyc(C_FLT + 3 + (C_UNP / 2) * C_MHZ);
    check("hpd_before_disable", int'(hpd_out), 1);
    en = 1'b0;
    wait_cyc(1);
    check("hpd_after_disable", int'(hpd_out), 0);
    connected = 1'b0;
    wait_cyc((C_UNP + 4) * C_MHZ);
    // High held while disabled produces nothing; enabling then qualifies it
    hpd = 1'b1;
    wait_cyc((C_PLUG + 4) * C_MHZ);
    check("hpd_disabled_high", int'(hpd_out), 0);
    en = 1'b1;
    k = cyc;
    push_timed(EV_PLUG, k + 1, C_PLUG);
    wait_cyc((C_PLUG + 2) * C_MHZ);
    connected = 1'b1;
    check("hpd_after_enable_plug", int'(hpd_out), 1);

    // Asynchronous reset while connected clears HPD_OUT at once
    rst = 1'b1;
    #1;
    check("hpd_async_rst", int'(hpd_out), 0);
    wait_cyc(3);
    rst = 1'b0;
    // Let it sit in QUAL, then reset again mid-QUAL
    wait_cyc(C_FLT + 3 + (C_PLUG / 2) * C_MHZ);
    rst = 1'b1;
    #1;
    check("rst_qual_hpd", int'(hpd_out), 0);
    check("rst_qual_plug", int'(plug), 0);
    wait_cyc(3);
    rst = 1'b0;
    k = cyc;
    push_timed(EV_PLUG, k + 3 + C_FLT, C_PLUG);
    wait_cyc(C_FLT + 4 + (C_PLUG + 2) * C_MHZ);
    connected = 1'b1;
    check("hpd_after_rst_plug", int'(hpd_out), 1);

    // Randomised segments
    for (int s = 0; s < 40; s++) begin
      if (!connected) begin
        if ($urandom_range(0, 2) == 0) seg_short_high();
        else                          seg_plug();
      end else begin
        case ($urandom_range(0, 5))
          0:       seg_con(0);
          1:       seg_con(1);
          2, 3:    seg_con(2);
          4:       seg_con(3);
          default: seg_con(4);
        endcase
      end
    end

    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #(10 * 90000);
    $display("[TB] FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1, "watchdog");
  end

endmodule
